// File: rtl/instr_fetch.sv
// Instruction fetch unit: holds the PC and instruction register, computes the next PC (jump/beq/sequential).
// Optional fetch-timeout watchdog enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  output logic        fetch_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_ERR} state_t;

  state_t      state, state_nxt;
  logic        take;
  logic        timeout;
  logic        jump_q, taken_q;
  logic [31:0] branch_off;
  logic [31:0] pc_next;

  // Handshake: imem_req is held high with a stable imem_addr until imem_ack;
  // a request completes in the cycle where req && ack, imem_rdata valid then.
  assign take = (state == S_REQ) && imem_ack;

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if ((state == S_REQ) && !imem_ack)
      cnt <= cnt + 1'b1;
    else
      cnt <= '0;
  end

  assign timeout   = (state == S_REQ) && !imem_ack && (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign fetch_err = (state == S_ERR);
`else
  assign timeout   = 1'b0;
  assign fetch_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ: begin
        if (imem_ack)
          state_nxt = S_HOLD;
        else if (timeout)
          state_nxt = S_ERR;
      end
      S_HOLD: if (!stall) state_nxt = S_REQ;
      S_ERR:  state_nxt = S_ERR;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req    = (state == S_REQ);
    instr_valid = (state == S_HOLD);
  end

  // Decoder controls only mean something while the held instruction is valid.
  assign jump_q     = jump && instr_valid;
  assign taken_q    = branch && zero && instr_valid;
  assign branch_off = {{14{instr[15]}}, instr[15:0], 2'b00};

  always_comb begin
    pc_next = pc_plus4;
    if (jump_q)
      pc_next = {pc_plus4[31:28], instr[25:0], 2'b00};
    else if (taken_q)
      pc_next = pc_plus4 + branch_off;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= {RESET_PC[31:2], 2'b00};
      instr <= 32'h0000_0000;
    end else begin
      if (take)
        instr <= imem_rdata;
      if ((state == S_HOLD) && !stall)
        pc <= pc_next;
    end
  end

  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;
  assign opcode    = instr[31:26];
  assign funct     = instr[5:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: expected fetch addresses are queued when a redirect
// is driven and popped when the DUT raises imem_req.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        jump;
  logic        branch;
  logic        zero;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        fetch_err;

  logic [31:0] exp_q[$];
  int          pass_cnt  = 0;
  int          total_cnt = 0;

  instr_fetch #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .jump(jump), .branch(branch), .zero(zero),
    .instr(instr), .opcode(opcode), .funct(funct), .pc(pc), .pc_plus4(pc_plus4),
    .instr_valid(instr_valid), .fetch_err(fetch_err)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Wait for a request (bounded), check its address against the scoreboard,
  // optionally hold off the ack, then check the captured instruction.
  task automatic fetch(input logic [31:0] rdata, input int delay);
    logic [31:0] exp_addr;
    int waited = 0;
    jump   = 1'($urandom_range(0, 1));
    branch = 1'($urandom_range(0, 1));
    zero   = 1'($urandom_range(0, 1));
    while (imem_req !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk("req_seen", {31'b0, imem_req}, 32'd1);
    exp_addr = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    chk("imem_addr", imem_addr, exp_addr);
    repeat (delay) begin
      @(negedge clk);
      chk("addr_stable", imem_addr, exp_addr);
      chk("req_held", {31'b0, imem_req}, 32'd1);
    end
    imem_ack   = 1'b1;
    imem_rdata = rdata;
    @(posedge clk);
    #1;
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    jump = 1'b0; branch = 1'b0; zero = 1'b0;
    @(negedge clk);
    chk("instr_valid", {31'b0, instr_valid}, 32'd1);
    chk("instr", instr, rdata);
    chk("opcode", {26'b0, opcode}, {26'b0, rdata[31:26]});
    chk("funct", {26'b0, funct}, {26'b0, rdata[5:0]});
    chk("pc", pc, exp_addr);
    chk("pc_plus4", pc_plus4, exp_addr + 32'd4);
    chk("req_in_hold", {31'b0, imem_req}, 32'd0);
  endtask

  // Leave S_HOLD with the given decoder controls; next_addr is the expected next fetch.
  task automatic redirect(input logic j, input logic b, input logic z, input logic [31:0] next_addr);
    jump = j; branch = b; zero = z; stall = 1'b0;
    exp_q.push_back(next_addr);
    @(posedge clk);
    #1;
    jump = 1'b0; branch = 1'b0; zero = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0;
    stall = 1'b0; jump = 1'b0; branch = 1'b0; zero = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_pc", pc, 32'h0000_0000);
    chk("rst_instr", instr, 32'h0000_0000);
    chk("rst_err", {31'b0, fetch_err}, 32'd0);
    chk("rst_pc_plus4", pc_plus4, 32'h0000_0004);

    reset = 1'b0;
    #1;
    chk("idle_req", {31'b0, imem_req}, 32'd0);
    @(negedge clk);
    chk("first_req", {31'b0, imem_req}, 32'd1);
    exp_q.push_back(32'h0000_0000);

    fetch(32'h8C08_0004, 1);
    chk("lw_opcode", {26'b0, opcode}, 32'h0000_0023);
    redirect(1'b0, 1'b0, 1'b0, 32'h0000_0004);
    fetch(32'h1000_FFFD, $urandom_range(0, 2));
    redirect(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    fetch(32'h0000_0020, $urandom_range(0, 2));
    redirect(1'b0, 1'b0, 1'b0, 32'h0000_0000);
    fetch(32'h0800_0002, $urandom_range(0, 2));
    redirect(1'b1, 1'b0, 1'b0, 32'h0000_0008);

    // stall in S_HOLD, with a stray ack that must be ignored
    stall = 1'b1;
    fetch(32'h1100_0003, 0);
    for (int i = 0; i < 5; i++) begin
      imem_ack = (i == 0); imem_rdata = 32'hDEAD_BEEF; jump = 1'b1;
      @(posedge clk);
      #1;
      imem_ack = 1'b0; jump = 1'b0;
      @(negedge clk);
      chk("stall_instr", instr, 32'h1100_0003);
      chk("stall_pc", pc, 32'h0000_0008);
      chk("stall_req", {31'b0, imem_req}, 32'd0);
      chk("stall_valid", {31'b0, instr_valid}, 32'd1);
    end
    redirect(1'b0, 1'b1, 1'b1, 32'h0000_0018);
    chk("req_after_stall", {31'b0, imem_req}, 32'd1);

    fetch(32'h0800_0002, $urandom_range(0, 2));
    redirect(1'b1, 1'b0, 1'b1, 32'h0000_0008);
    fetch(32'h1100_0003, $urandom_range(0, 2));
    redirect(1'b0, 1'b1, 1'b0, 32'h0000_000C);
    fetch(32'h0BFF_FFFF, $urandom_range(0, 2));
    redirect(1'b1, 1'b0, 1'b0, 32'h0FFF_FFFC);
    fetch(32'h0000_0000, $urandom_range(0, 2));
    redirect(1'b0, 1'b0, 1'b0, 32'h1000_0000);
    fetch(32'h0800_0040, $urandom_range(0, 2));
    redirect(1'b1, 1'b1, 1'b1, 32'h1000_0100);

    // no ack: watchdog behaviour depends on the build
    chk("to_addr", imem_addr, exp_q.size() > 0 ? exp_q.pop_front() : 32'hxxxx_xxxx);
    for (int i = 1; i <= 20; i++) begin
`ifdef FETCH_TIMEOUT_EN
      chk("to_err", {31'b0, fetch_err}, (i > 16) ? 32'd1 : 32'd0);
      chk("to_req", {31'b0, imem_req}, (i > 16) ? 32'd0 : 32'd1);
      chk("to_valid", {31'b0, instr_valid}, 32'd0);
`else
      chk("to_err", {31'b0, fetch_err}, 32'd0);
      chk("to_req", {31'b0, imem_req}, 32'd1);
`endif
      @(negedge clk);
    end

    // reset during a pending fetch with a simultaneous ack
    reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
    @(negedge clk);
    chk("mid_rst_req", {31'b0, imem_req}, 32'd0);
    chk("mid_rst_instr", instr, 32'h0000_0000);
    chk("mid_rst_pc", pc, 32'h0000_0000);
    chk("mid_rst_err", {31'b0, fetch_err}, 32'd0);
    chk("mid_rst_valid", {31'b0, instr_valid}, 32'd0);
    reset = 1'b0;
    #1;
    chk("re_idle_req", {31'b0, imem_req}, 32'd0);
    @(negedge clk);
    chk("re_first_req", {31'b0, imem_req}, 32'd1);
    exp_q.push_back(32'h0000_0000);
    fetch(32'h2108_0001, 0);
    chk("q_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
